// File: rtl/resampler_pkg.sv
// Shared definitions for the multichannel resampler and its frame collector.
// Sample width, channel-count defaults and the collector state encoding live here.
package resampler_pkg;

   localparam int SAMPLE_W        = 24;
   localparam int NUM_CH_DEF      = 8;
   localparam int NUM_CH_LOG2_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_COLLECT,
      ST_PRESENT
   } collector_state_e;

endpackage

// File: rtl/resampler_frame_slots.sv
// Per-channel sample register bank with a one-hot-or-more write mask.
// Every channel whose mask bit is set captures the shared write word.
module resampler_frame_slots
   import resampler_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          wr_en_i,
   input  logic [SAMPLE_W-1:0]        wr_data_i,
   output logic [SAMPLE_W*NUM_CH-1:0] slots_o
);

   logic [SAMPLE_W*NUM_CH-1:0] slots_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en_i[k]) begin
               slots_q[k*SAMPLE_W +: SAMPLE_W] <= wr_data_i;
            end
         end
      end
   end

   assign slots_o = slots_q;

endmodule

// File: rtl/resampler_frame_collector.sv
// Requests one sample per channel on each frame tick, assembles the replies into a
// frame, and presents it downstream; flags channels that never answer and dropped ticks.
module resampler_frame_collector
   import resampler_pkg::*;
#(
   parameter int NUM_CH       = NUM_CH_DEF,
   parameter int NUM_CH_LOG2  = NUM_CH_LOG2_DEF,
   parameter int TIMEOUT      = 1024,
   parameter int TIMEOUT_LOG2 = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_tick_i,
   output logic [NUM_CH-1:0]          pop_o,
   input  logic [SAMPLE_W-1:0]        data_i,
   input  logic [NUM_CH-1:0]          ack_i,
   output logic [SAMPLE_W*NUM_CH-1:0] frame_o,
   output logic                       frame_valid_o,
   input  logic                       frame_ready_i,
   output logic [NUM_CH-1:0]          underrun_o,
   input  logic                       clear_i,
   output logic                       missed_tick_o
);

   if ((NUM_CH > (1 << NUM_CH_LOG2)) || (TIMEOUT > (1 << TIMEOUT_LOG2))) begin : g_bad_params
      $error("resampler_frame_collector: LOG2 parameters too small");
   end

   localparam logic [TIMEOUT_LOG2-1:0] TIMER_LAST = TIMEOUT_LOG2'(TIMEOUT - 1);

   collector_state_e          state_q, state_d;
   logic [NUM_CH-1:0]         got_q, got_d;
   logic [TIMEOUT_LOG2-1:0]   timer_q, timer_d;
   logic [NUM_CH-1:0]         underrun_q, underrun_d;
   logic                      missed_q, missed_d;
   logic [NUM_CH-1:0]         slot_wr_en;
   logic [NUM_CH-1:0]         new_underrun;
   logic [NUM_CH-1:0]         got_after;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         got_q      <= '0;
         timer_q    <= '0;
         underrun_q <= '0;
         missed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         got_q      <= got_d;
         timer_q    <= timer_d;
         underrun_q <= underrun_d;
         missed_q   <= missed_d;
      end
   end

   assign got_after = got_q | ack_i;

   // A completion landing on the last timer cycle takes priority over the timeout.
   always_comb begin
      state_d      = state_q;
      got_d        = got_q;
      timer_d      = timer_q;
      slot_wr_en   = '0;
      new_underrun = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_tick_i) begin
               state_d = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            got_d   = '0;
            timer_d = '0;
            state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            slot_wr_en = ack_i & ~got_q;
            got_d      = got_after;
            timer_d    = timer_q + TIMEOUT_LOG2'(1);
            if (&got_after) begin
               state_d = ST_PRESENT;
            end else if (timer_q == TIMER_LAST) begin
               state_d      = ST_PRESENT;
               new_underrun = ~got_after;
            end
         end
         ST_PRESENT: begin
            if (frame_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign underrun_d = (clear_i ? '0 : underrun_q) | new_underrun;
   assign missed_d   = frame_tick_i && (state_q != ST_IDLE);

   resampler_frame_slots #(
      .NUM_CH (NUM_CH)
   ) u_slots (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (slot_wr_en),
      .wr_data_i (data_i),
      .slots_o   (frame_o)
   );

   assign pop_o         = {NUM_CH{state_q == ST_REQUEST}};
   assign frame_valid_o = (state_q == ST_PRESENT);
   assign underrun_o    = underrun_q;
   assign missed_tick_o = missed_q;

endmodule

// File: tb/tb_resampler_frame_collector.sv
// Self-checking bench for resampler_frame_collector: a frame-level reference model
// checked every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_resampler_frame_collector;

   localparam int NCH     = 8;
   localparam int SW      = 24;
   localparam int FW      = SW * NCH;
   localparam int TIMEOUT = 32;

   localparam logic [1:0] PH_WAIT   = 2'd0;
   localparam logic [1:0] PH_POP    = 2'd1;
   localparam logic [1:0] PH_GATHER = 2'd2;
   localparam logic [1:0] PH_HOLD   = 2'd3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           frame_tick_i;
   logic [NCH-1:0] pop_o;
   logic [SW-1:0]  data_i;
   logic [NCH-1:0] ack_i;
   logic [FW-1:0]  frame_o;
   logic           frame_valid_o;
   logic           frame_ready_i;
   logic [NCH-1:0] underrun_o;
   logic           clear_i;
   logic           missed_tick_o;

   int testsRun    = 0;
   int testsFailed = 0;
   int popCount    = 0;

   resampler_frame_collector #(
      .NUM_CH       (NCH),
      .NUM_CH_LOG2  (3),
      .TIMEOUT      (TIMEOUT),
      .TIMEOUT_LOG2 (5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_tick_i  (frame_tick_i),
      .pop_o         (pop_o),
      .data_i        (data_i),
      .ack_i         (ack_i),
      .frame_o       (frame_o),
      .frame_valid_o (frame_valid_o),
      .frame_ready_i (frame_ready_i),
      .underrun_o    (underrun_o),
      .clear_i       (clear_i),
      .missed_tick_o (missed_tick_o)
   );

   always #5 clk = ~clk;

   // Frame-level view: which phase of a frame we are in, the absolute cycle the
   // request went out, which channels answered, and the frame held downstream.
   typedef struct packed {
      logic [1:0]     phase;
      logic [31:0]    now;
      logic [31:0]    start;
      logic [NCH-1:0] got;
      logic [FW-1:0]  frame;
      logic [NCH-1:0] under;
      logic           missed;
   } model_t;

   model_t m;

   function automatic model_t modelStep(input model_t s, input logic tick,
                                        input logic [NCH-1:0] ack, input logic [SW-1:0] data,
                                        input logic ready, input logic clear);
      model_t r = s;
      logic [NCH-1:0] missing = '0;
      r.now    = s.now + 1;
      r.missed = tick && (s.phase != PH_WAIT);
      case (s.phase)
         PH_WAIT: if (tick) r.phase = PH_POP;
         PH_POP: begin
            r.phase = PH_GATHER;
            r.got   = '0;
            r.start = s.now;
         end
         PH_GATHER: begin
            for (int k = 0; k < NCH; k++) begin
               if (ack[k] && !s.got[k]) r.frame[k*SW +: SW] = data;
            end
            r.got = s.got | ack;
            if (r.got == {NCH{1'b1}}) begin
               r.phase = PH_HOLD;
            end else if (s.now == s.start + TIMEOUT) begin
               r.phase = PH_HOLD;
               missing = ~r.got;
            end
         end
         default: if (ready) r.phase = PH_WAIT;
      endcase
      r.under = (clear ? '0 : s.under) | missing;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= modelStep(m, frame_tick_i, ack_i, data_i, frame_ready_i, clear_i);
   end

   task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                              input logic [FW-1:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Cycle-by-cycle comparison against the model on the falling edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checkOutput("cyc_pop",      FW'(pop_o),         FW'((m.phase == PH_POP) ? 8'hFF : 8'h00));
         checkOutput("cyc_valid",    FW'(frame_valid_o), FW'(m.phase == PH_HOLD));
         checkOutput("cyc_frame",    frame_o,            m.frame);
         checkOutput("cyc_underrun", FW'(underrun_o),    FW'(m.under));
         checkOutput("cyc_missed",   FW'(missed_tick_o), FW'(m.missed));
      end
   end

   always @(negedge clk) begin
      if (pop_o == 8'hFF) popCount <= popCount + 1;
   end

   // Drive one cycle's worth of inputs, then step to just after the next rising edge.
   task automatic applyStimulus(input logic tick, input logic [NCH-1:0] ack,
                                input logic [SW-1:0] data, input logic ready, input logic clear);
      frame_tick_i  = tick;
      ack_i         = ack;
      data_i        = data;
      frame_ready_i = ready;
      clear_i       = clear;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input logic clear);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, clear);
   endtask

   task automatic startFrame();
      applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int popBefore;
      int waited;

      rst_n         = 1'b0;
      frame_tick_i  = 1'b0;
      ack_i         = '0;
      data_i        = '0;
      frame_ready_i = 1'b0;
      clear_i       = 1'b0;
      #12;
      checkOutput("reset_pop",      FW'(pop_o),         '0);
      checkOutput("reset_frame",    frame_o,            '0);
      checkOutput("reset_valid",    FW'(frame_valid_o), '0);
      checkOutput("reset_underrun", FW'(underrun_o),    '0);
      checkOutput("reset_missed",   FW'(missed_tick_o), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycles(2, 1'b0);

      $display("[TB] normal frame");
      popBefore = popCount;
      applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
      checkOutput("normal_pop_request", FW'(pop_o), FW'(8'hFF));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("normal_pop_dropped", FW'(pop_o), '0);
      for (int k = 0; k < NCH; k++) begin
         applyStimulus(1'b0, NCH'(1 << k), SW'(k * 256), 1'b0, 1'b0);
         if (k == NCH - 1) checkOutput("normal_valid_after_last_ack", FW'(frame_valid_o), FW'(1'b1));
         else              checkOutput("normal_not_valid_early", FW'(frame_valid_o), '0);
         if (k != NCH - 1) idleCycles(2, 1'b0);
      end
      checkOutput("normal_frame", frame_o,
                  192'h000700_000600_000500_000400_000300_000200_000100_000000);
      checkOutput("normal_underrun", FW'(underrun_o), '0);
      checkOutput("normal_pop_once", FW'(popCount - popBefore), FW'(1));
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("normal_valid_drop", FW'(frame_valid_o), '0);

      $display("[TB] backpressure");
      startFrame();
      applyStimulus(1'b0, 8'hFF, 24'h0ABCDE, 1'b0, 1'b0);
      idleCycles(20, 1'b0);
      applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
      checkOutput("bp_missed_pulse", FW'(missed_tick_o), FW'(1'b1));
      idleCycles(1, 1'b0);
      checkOutput("bp_missed_clear", FW'(missed_tick_o), '0);
      idleCycles(28, 1'b0);
      checkOutput("bp_frame_stable", frame_o,
                  192'h0ABCDE_0ABCDE_0ABCDE_0ABCDE_0ABCDE_0ABCDE_0ABCDE_0ABCDE);
      checkOutput("bp_valid_held", FW'(frame_valid_o), FW'(1'b1));
      popBefore = popCount;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      idleCycles(4, 1'b0);
      checkOutput("bp_idle_valid", FW'(frame_valid_o), '0);
      checkOutput("bp_no_pop", FW'(popCount - popBefore), '0);

      $display("[TB] timeout");
      startFrame();
      applyStimulus(1'b0, 8'hFF, 24'h123456, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      startFrame();
      applyStimulus(1'b0, 8'hDF, 24'h654321, 1'b0, 1'b0);
      waited = 0;
      while (!frame_valid_o && waited < 40) begin
         idleCycles(1, 1'b0);
         waited++;
      end
      checkOutput("to_cycles", FW'(waited), FW'(31));
      checkOutput("to_frame", frame_o,
                  192'h654321_654321_123456_654321_654321_654321_654321_654321);
      checkOutput("to_underrun", FW'(underrun_o), FW'(8'h20));
      applyStimulus(1'b0, 8'h20, 24'h777777, 1'b1, 1'b0);
      checkOutput("to_late_ack_slot5", FW'(frame_o[5*SW +: SW]), FW'(24'h123456));
      checkOutput("to_underrun_sticky", FW'(underrun_o), FW'(8'h20));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("to_clear", FW'(underrun_o), '0);

      $display("[TB] duplicate and late ack");
      startFrame();
      applyStimulus(1'b0, 8'h04, 24'hAAAAAA, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h04, 24'hBBBBBB, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFB, 24'h111111, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h04, 24'hCCCCCC, 1'b0, 1'b0);
      checkOutput("dup_frame", frame_o,
                  192'h111111_111111_111111_111111_111111_AAAAAA_111111_111111);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h04, 24'hDDDDDD, 1'b0, 1'b0);
      checkOutput("dup_slot2_idle", FW'(frame_o[2*SW +: SW]), FW'(24'hAAAAAA));

      $display("[TB] completion on final timer cycle");
      startFrame();
      applyStimulus(1'b0, 8'h7F, 24'h222222, 1'b0, 1'b0);
      idleCycles(TIMEOUT - 2, 1'b0);
      checkOutput("coin_not_yet", FW'(frame_valid_o), '0);
      applyStimulus(1'b0, 8'h80, 24'h333333, 1'b0, 1'b0);
      checkOutput("coin_valid", FW'(frame_valid_o), FW'(1'b1));
      checkOutput("coin_underrun", FW'(underrun_o), '0);
      checkOutput("coin_slot7", FW'(frame_o[7*SW +: SW]), FW'(24'h333333));
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

      $display("[TB] timeout while clear held");
      startFrame();
      idleCycles(TIMEOUT, 1'b1);
      checkOutput("clr_race_valid", FW'(frame_valid_o), FW'(1'b1));
      checkOutput("clr_race_underrun", FW'(underrun_o), FW'(8'hFF));
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      checkOutput("clr_race_cleared", FW'(underrun_o), '0);

      $display("[TB] reset mid-collect");
      startFrame();
      applyStimulus(1'b0, 8'h01, 24'h444444, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h02, 24'h444444, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h04, 24'h444444, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_frame", frame_o, '0);
      checkOutput("rst_valid", FW'(frame_valid_o), '0);
      checkOutput("rst_pop", FW'(pop_o), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
      checkOutput("rst_new_pop", FW'(pop_o), FW'(8'hFF));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF, 24'h555555, 1'b0, 1'b0);
      checkOutput("rst_new_frame", frame_o,
                  192'h555555_555555_555555_555555_555555_555555_555555_555555);
      checkOutput("rst_new_underrun", FW'(underrun_o), '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      idleCycles(2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
